// File: rtl/feed_forward_node.sv
// Single-neuron float32 MAC: serial (weight, data) terms plus bias, optional LeakyReLU.
// Define FF_NODE_EXCEPTION_FLAG_EN to add o_exception (Inf/NaN or overflow seen in the neuron).
module feed_forward_node #(
  parameter int DATA_WIDTH           = 32,
  parameter int NUMBER_OF_INPUT_NODE = 32,
  parameter int LEAKYRELU_ENABLE     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
`ifdef FF_NODE_EXCEPTION_FLAG_EN
  ,
  output logic                  o_exception
`endif
);

  localparam int CNT_W = $clog2(NUMBER_OF_INPUT_NODE + 1);
  localparam logic [31:0] ALPHA = 32'h3C23D70A;

  // Truncating multiply; zero/denormal operands flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic signed [9:0]  e;
    logic [22:0]        m;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
        + $signed({9'd0, p[47]});
    m = p[47] ? p[46:24] : p[45:23];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    else if (e >= 10'sd255)                   return {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                     return {s, 31'd0};
    else                                      return {s, e[7:0], m};
  endfunction

  // Truncating add. The aligned smaller operand is kept as floor(exact), and on
  // subtraction the sticky bit is subtracted, so both paths yield floor(|sum|).
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       mx, my_full, my, mask, diff, norm;
    logic              sticky, found;
    logic [27:0]       sum;
    logic [8:0]        es;
    logic [4:0]        lz;
    logic signed [9:0] ed;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d       = x[30:23] - y[30:23];
    mx      = {1'b1, x[22:0], 3'b000};
    my_full = {1'b1, y[22:0], 3'b000};
    if (d >= 8'd27) begin
      my     = '0;
      sticky = 1'b1;
    end else begin
      mask   = (27'd1 << d) - 27'd1;
      my     = my_full >> d;
      sticky = |(my_full & mask);
    end
    if (x[31] == y[31]) begin
      sum = {1'b0, mx} + {1'b0, my};
      if (sum[27]) begin
        es = {1'b0, x[30:23]} + 9'd1;
        if (es >= 9'd255) return {x[31], 8'hFF, 23'd0};
        return {x[31], es[7:0], sum[26:4]};
      end
      return {x[31], x[30:23], sum[25:3]};
    end
    diff = mx - my - {26'd0, sticky};
    if (diff == 27'd0) return 32'd0;
    lz    = '0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && diff[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    norm = diff << lz;
    ed   = $signed({2'b00, x[30:23]}) - $signed({5'd0, lz});
    if (ed <= 10'sd0) return {x[31], 31'd0};
    return {x[31], ed[7:0], norm[25:3]};
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cnt_last;
  logic             v1_q, first1_q, last1_q, last2_q;
  logic [31:0]      prod_q, prod_d, acc_q, acc_d, sum_d, act_d;
  logic [31:0]      o_data_q;
  logic             o_valid_q;

  always_comb begin
    cnt_last = (cnt_q == CNT_W'(NUMBER_OF_INPUT_NODE));
    cnt_d    = cnt_q;
    if (i_valid) cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
    prod_d = fp_mul(i_weight, i_data);
    sum_d  = fp_add(acc_q, prod_q);
    acc_d  = first1_q ? prod_q : sum_d;
    // -0.0 has a zero magnitude and therefore passes through unscaled.
    if (LEAKYRELU_ENABLE != 0 && acc_q[31] && acc_q[30:0] != 31'd0)
      act_d = fp_mul(acc_q, ALPHA);
    else
      act_d = acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      first1_q  <= 1'b0;
      last1_q   <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      last2_q   <= 1'b0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      v1_q  <= i_valid;
      if (i_valid) begin
        prod_q   <= prod_d;
        first1_q <= (cnt_q == '0);
        last1_q  <= cnt_last;
      end
      if (v1_q) acc_q <= acc_d;
      last2_q   <= v1_q & last1_q;
      o_valid_q <= last2_q;
      if (last2_q) o_data_q <= act_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

`ifdef FF_NODE_EXCEPTION_FLAG_EN
  logic exc1_q, exc2_q, exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc1_q <= 1'b0;
      exc2_q <= 1'b0;
      exc_q  <= 1'b0;
    end else begin
      if (i_valid) exc1_q <= (prod_d[30:23] == 8'hFF);
      if (v1_q) begin
        if (first1_q) exc2_q <= exc1_q;
        else          exc2_q <= exc2_q | exc1_q | (sum_d[30:23] == 8'hFF);
      end
      if (v1_q && first1_q) exc_q <= 1'b0;
      if (last2_q) exc_q <= exc2_q | (act_d[30:23] == 8'hFF);
    end
  end

  assign o_exception = exc_q;
`endif

endmodule

// File: tb/tb_feed_forward_node.sv
// Scoreboard bench for feed_forward_node: N=2 (LeakyReLU on/off) and N=32 instances.
module tb_feed_forward_node;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        v2, v32;
  logic [31:0] w2, d2, w32, d32;
  logic [31:0] od_a, od_b, od_c;
  logic        ov_a, ov_b, ov_c;
`ifdef FF_NODE_EXCEPTION_FLAG_EN
  logic        ex_a, ex_b, ex_c;
`endif

  exp_t q_a[$], q_b[$], q_c[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] t1w [3] = '{32'h3F000000, 32'h3E800000, 32'h3F800000};
  logic [31:0] t1d [3] = '{32'h40000000, 32'h40800000, 32'h3F800000};
  logic [31:0] t2w [3] = '{32'hBF800000, 32'h00000000, 32'h00000000};
  logic [31:0] t2d [3] = '{32'h40000000, 32'h00000000, 32'h3F800000};

  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUT_NODE(2), .LEAKYRELU_ENABLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_weight(w2), .i_data(d2),
    .o_data(od_a), .o_valid(ov_a)
`ifdef FF_NODE_EXCEPTION_FLAG_EN
    , .o_exception(ex_a)
`endif
  );

  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUT_NODE(2), .LEAKYRELU_ENABLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_weight(w2), .i_data(d2),
    .o_data(od_b), .o_valid(ov_b)
`ifdef FF_NODE_EXCEPTION_FLAG_EN
    , .o_exception(ex_b)
`endif
  );

  feed_forward_node #(.DATA_WIDTH(32), .NUMBER_OF_INPUT_NODE(32), .LEAKYRELU_ENABLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_valid(v32), .i_weight(w32), .i_data(d32),
    .o_data(od_c), .o_valid(ov_c)
`ifdef FF_NODE_EXCEPTION_FLAG_EN
    , .o_exception(ex_c)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Output monitors: pop the scoreboard on every o_valid pulse.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ov_a) begin
      if (q_a.size() == 0) check("a_spurious_valid", 32'(ov_a), 32'd0);
      else begin
        e = q_a.pop_front();
        $display("[%0d] a result %h (expected %h)", cyc, od_a, e.data);
        check("a_data", od_a, e.data);
        check("a_latency", cyc, e.cyc);
`ifdef FF_NODE_EXCEPTION_FLAG_EN
        check("a_exception", 32'(ex_a), 32'd0);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (ov_b) begin
      if (q_b.size() == 0) check("b_spurious_valid", 32'(ov_b), 32'd0);
      else begin
        e = q_b.pop_front();
        $display("[%0d] b result %h (expected %h)", cyc, od_b, e.data);
        check("b_data", od_b, e.data);
        check("b_latency", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (ov_c) begin
      if (q_c.size() == 0) check("c_spurious_valid", 32'(ov_c), 32'd0);
      else begin
        e = q_c.pop_front();
        $display("[%0d] c result %h (expected %h)", cyc, od_c, e.data);
        check("c_data", od_c, e.data);
        check("c_latency", cyc, e.cyc);
      end
    end
  end

  task automatic term2(input logic [31:0] w, input logic [31:0] d, input bit last,
                       input logic [31:0] ea, input logic [31:0] eb);
    @(posedge clk); #1;
    v2 = 1'b1; w2 = w; d2 = d;
    if (last) begin
      q_a.push_back('{data: ea, cyc: cyc + 3});
      q_b.push_back('{data: eb, cyc: cyc + 3});
    end
  endtask

  task automatic idle2(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      v2 = 1'b0; w2 = '0; d2 = '0;
    end
  endtask

  // which=1: 0.5*2 + 0.25*4 + 1 = 3.0; which=2: -1*2 + 0 + 0 = -2.0.
  task automatic neuron2(input int which, input int gap);
    for (int i = 0; i < 3; i++) begin
      if (which == 1) term2(t1w[i], t1d[i], i == 2, 32'h40400000, 32'h40400000);
      else            term2(t2w[i], t2d[i], i == 2, 32'hBCA3D70A, 32'hC0000000);
      if (gap > 0) idle2(gap);
    end
  endtask

  task automatic neuron32();
    for (int i = 0; i < 33; i++) begin
      @(posedge clk); #1;
      v32 = 1'b1; w32 = 32'h3F800000; d32 = 32'h3F800000;
      if (i == 32) q_c.push_back('{data: 32'h42040000, cyc: cyc + 3});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v2 = 1'b0; w2 = '0; d2 = '0;
    v32 = 1'b0; w32 = '0; d32 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_valid", 32'(ov_a), 32'd0);
    check("rst_a_data", od_a, 32'd0);
    check("rst_b_valid", 32'(ov_b), 32'd0);
    check("rst_b_data", od_b, 32'd0);
    check("rst_c_valid", 32'(ov_c), 32'd0);
    check("rst_c_data", od_c, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    neuron2(1, 0); idle2(6);
    neuron2(2, 0); idle2(6);
    neuron2(1, 0); neuron2(2, 0); idle2(6);
    neuron2(1, 5); idle2(6);

    // Partial neuron aborted by reset; the next stream must start at term 0.
    term2(t1w[0], t1d[0], 1'b0, '0, '0);
    term2(t1w[1], t1d[1], 1'b0, '0, '0);
    idle2(1);
    rst_n = 1'b0;
    #2;
    check("midrst_a_valid", 32'(ov_a), 32'd0);
    check("midrst_a_data", od_a, 32'd0);
    check("midrst_b_data", od_b, 32'd0);
    idle2(2);
    rst_n = 1'b1;
    neuron2(1, 0); idle2(6);

    neuron32(); neuron32();
    @(posedge clk); #1;
    v32 = 1'b0; w32 = '0; d32 = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    check("a_pending", q_a.size(), 32'd0);
    check("b_pending", q_b.size(), 32'd0);
    check("c_pending", q_c.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/feed_forward_node.md
Name: feed_forward_node

Overview:
- Single-neuron floating-point MAC used by the DQN feed-forward engine; one instance per layer type.
- Input-layer instance: NUMBER_OF_INPUT_NODE=2. Hidden/output instances: 32.
- Consumes a serial stream of (weight, data) pairs: NUMBER_OF_INPUT_NODE data terms, then one bias term (data supplied as 1.0 by the parent).
- Emits the dot product, optionally passed through LeakyReLU.
- All values are IEEE-754 single precision.

Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- NUMBER_OF_INPUT_NODE, 32, data terms per neuron; the bias term is extra, so NUMBER_OF_INPUT_NODE+1 terms per result.
- LEAKYRELU_ENABLE, 1, 1 = apply LeakyReLU (alpha=0.01) to the result; 0 = pass the sum through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  i_weight/i_data hold one term this cycle.
- i_weight  in  DATA_WIDTH  float weight.
- i_data  in  DATA_WIDTH  float activation (1.0 = 0x3F800000 for the bias term).
- o_data  out  DATA_WIDTH  float neuron result.
- o_valid  out  1  one-cycle pulse; o_data is new.

Behaviour:
- Reset: o_valid=0, o_data=0, term counter=0, accumulator=0, all pipeline valids=0. Asserting reset mid-neuron discards the partial sum; the next i_valid is term 0.
- Stage 1 (cycle after i_valid): product register = i_weight*i_data; a tag marks first and last term. The term counter runs 0..NUMBER_OF_INPUT_NODE and wraps to 0 after the last term.
- Stage 2: if the tag is first, acc = product; otherwise acc = acc + product.
- Stage 3: after the last term is accumulated, o_data = act(acc) and o_valid = 1 for exactly one cycle.
- Latency: o_valid is asserted 3 cycles after the i_valid of the bias term.
- i_valid may have gaps of any length; the counter and accumulator hold while i_valid=0.
- Back-to-back neurons: term 0 of the next neuron may arrive the cycle after the previous bias term. The first-term tag restarts the accumulator without a bubble.
- Throughput: one term per cycle.
- o_data holds its value between pulses.
- No backpressure; the parent must accept o_valid.
- Float arithmetic (both multiplier and adder):
  - normalised operands; denormal inputs and results flush to signed zero;
  - rounding is truncation (toward zero);
  - exponent overflow gives signed infinity (exp=0xFF, mant=0);
  - Inf/NaN operands are not specially handled; the result is don't-care but must not hang the pipeline;
  - zero operands give exact zero;
  - x + (-x) gives +0.
- Activation:
  - LEAKYRELU_ENABLE=1: if the sign bit of acc is 1 and acc is nonzero, result = acc*0x3C23D70A (0.01) using the same multiplier rules; otherwise result = acc.
  - LEAKYRELU_ENABLE=0: result = acc.
  - -0.0 passes unchanged.

Optional Feature:
- Macro FF_NODE_EXCEPTION_FLAG_EN.
- When defined: adds output port o_exception (1 bit), valid with o_valid. It is 1 if o_data has exponent 0xFF (Inf/NaN) or any stage overflowed to infinity during that neuron. It clears at the first term of the next neuron and resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=2, LEAKY=1:
  - weights 0x3F000000, 0x3E800000, 0x3F800000;
  - data 0x40000000, 0x40800000, 0x3F800000 (consecutive cycles);
  - required: o_data=0x40400000 (3.0), o_valid pulses exactly 3 cycles after the bias term.
- N=2:
  - weights 0xBF800000, 0, 0; data 0x40000000, 0, 0x3F800000;
  - LEAKY=1 gives o_data=0xBCA3D70A (-0.02);
  - LEAKY=0 gives 0xC0000000.
- Back-to-back:
  - two neurons streamed with no gap (6 consecutive i_valid cycles, values as in test 1, then test 2);
  - required: two o_valid pulses 3 cycles apart, results 0x40400000 then 0xBCA3D70A.
- Gapped input:
  - test 1 with i_valid low 5 cycles between each term;
  - required: same result 0x40400000; o_valid 3 cycles after the bias term.
- Reset mid-neuron:
  - assert rst_n low after term 1 of a neuron, release, then send test 1 in full;
  - required: o_valid/o_data zero during reset, single correct result 0x40400000.
- N=32:
  - all weights 0x3F800000, all data 0x3F800000, bias data 1.0;
  - required: o_data=0x42040000 (33.0).
